// File: rtl/fib_conv_scheduler.sv
// Round-robin scheduler sharing one binary-to-Fibonacci converter among N_REQ lanes.
// Optional converter watchdog with FLUSH recovery is compiled in with `define FIB_TIMEOUT_EN.
module fib_conv_scheduler #(
  parameter int N_REQ          = 4,
  parameter int DW             = 16,
  parameter int RW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      grant,
  output logic [DW-1:0]         conv_input,
  output logic                  conv_begin,
  input  logic                  conv_done,
  input  logic [RW-1:0]         conv_result,
  output logic                  conv_rst_n,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [RW-1:0]         resp_data,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3
`ifdef FIB_TIMEOUT_EN
    , FLUSH = 3'd4
`endif
  } state_t;

  state_t              state_r, state_s;
  logic [PW-1:0]       ptr_r, ptr_s;
  logic [PW-1:0]       owner_r, owner_s;
  logic [PW-1:0]       winner_s, cand_s;
  logic                found_s;
  logic [N_REQ-1:0]    grant_r, grant_s;
  logic [N_REQ-1:0]    resp_valid_r, resp_valid_s;
  logic [DW-1:0]       conv_input_r, conv_input_s;
  logic [RW-1:0]       resp_data_r, resp_data_s;
  logic                conv_begin_r, conv_begin_s;
  logic                busy_r, busy_s;
  logic                timeout_err_r, timeout_err_s;
  logic                conv_rst_n_r, conv_rst_n_s;

  // Lane index modulo N_REQ; inputs never exceed 2*N_REQ-2, so one subtract suffices.
  function automatic logic [PW-1:0] lane_wrap(input logic [PW:0] v);
    logic [PW:0] t;
    t = (v >= (PW+1)'(N_REQ)) ? v - (PW+1)'(N_REQ) : v;
    return t[PW-1:0];
  endfunction

`ifdef FIB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] wait_cnt_r;
  logic          flush_cnt_r;
  logic          timeout_hit_s;

  assign timeout_hit_s = (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter, zero whenever not in WAIT so it clears on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r != WAIT) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end
  end

  // FLUSH cycle counter: FLUSH lasts exactly two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_r <= 1'b0;
    end else if (state_r != FLUSH) begin
      flush_cnt_r <= 1'b0;
    end else begin
      flush_cnt_r <= 1'b1;
    end
  end
`endif

  // Round-robin pick: first requesting lane scanning from ptr upward with wrap.
  always_comb begin
    winner_s = ptr_r;
    found_s  = 1'b0;
    cand_s   = ptr_r;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = lane_wrap({1'b0, ptr_r} + (PW+1)'(i));
      if (!found_s && req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; conv_done outside WAIT is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) state_s = ISSUE;
        else         state_s = IDLE;
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (conv_done) begin
          state_s = RESP;
`ifdef FIB_TIMEOUT_EN
        end else if (timeout_hit_s) begin
          state_s = FLUSH;
`endif
        end else begin
          state_s = WAIT;
        end
      end
      RESP: state_s = IDLE;
`ifdef FIB_TIMEOUT_EN
      FLUSH: begin
        if (flush_cnt_r) state_s = RESP;
        else             state_s = FLUSH;
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // Next values for the registered outputs, keyed on the current state.
  always_comb begin
    grant_s       = '0;
    resp_valid_s  = '0;
    conv_begin_s  = 1'b0;
    timeout_err_s = 1'b0;
    conv_input_s  = conv_input_r;
    resp_data_s   = resp_data_r;
    owner_s       = owner_r;
    ptr_s         = ptr_r;
    busy_s        = (state_s != IDLE);
`ifdef FIB_TIMEOUT_EN
    conv_rst_n_s  = (state_s != FLUSH);
`else
    conv_rst_n_s  = 1'b1;
`endif
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s[winner_s] = 1'b1;
          conv_input_s      = req_data[winner_s*DW +: DW];
          owner_s           = winner_s;
        end else begin
          owner_s           = owner_r;
        end
      end
      ISSUE: conv_begin_s = 1'b1;
      WAIT: begin
        if (conv_done) begin
          resp_data_s           = conv_result;
          resp_valid_s[owner_r] = 1'b1;
`ifdef FIB_TIMEOUT_EN
        end else if (timeout_hit_s) begin
          timeout_err_s         = 1'b1;
          resp_data_s           = '0;
`endif
        end else begin
          resp_data_s           = resp_data_r;
        end
      end
      RESP: ptr_s = lane_wrap({1'b0, owner_r} + (PW+1)'(1));
`ifdef FIB_TIMEOUT_EN
      FLUSH: begin
        if (flush_cnt_r) resp_valid_s[owner_r] = 1'b1;
        else             resp_valid_s          = '0;
      end
`endif
      default: conv_begin_s = 1'b0;
    endcase
  end

  // Output and bookkeeping registers; reset holds the converter in reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r       <= '0;
      resp_valid_r  <= '0;
      conv_input_r  <= '0;
      resp_data_r   <= '0;
      conv_begin_r  <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      conv_rst_n_r  <= 1'b0;
      owner_r       <= '0;
      ptr_r         <= '0;
    end else begin
      grant_r       <= grant_s;
      resp_valid_r  <= resp_valid_s;
      conv_input_r  <= conv_input_s;
      resp_data_r   <= resp_data_s;
      conv_begin_r  <= conv_begin_s;
      busy_r        <= busy_s;
      timeout_err_r <= timeout_err_s;
      conv_rst_n_r  <= conv_rst_n_s;
      owner_r       <= owner_s;
      ptr_r         <= ptr_s;
    end
  end

  assign grant       = grant_r;
  assign resp_valid  = resp_valid_r;
  assign conv_input  = conv_input_r;
  assign resp_data   = resp_data_r;
  assign conv_begin  = conv_begin_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign conv_rst_n  = conv_rst_n_r;

endmodule
